uart_rx_frame_ctrl: RTL and testbench

Frame-level controller sitting directly downstream of `uart_rx_wrapper`. It consumes the byte/valid/error stream and sequences it through a sync/length/payload/checksum frame format. It also supervises inter-byte timeouts and buffers one validated payload for the flight-control logic, which reads it out and acknowledges it. It is the single owner of the receive byte stream; nothing else consumes `uart_rx_wrapper` output.

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 33 +++
 rtl/uart_rx_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receive path.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_HOLD    = 3'd4
  } frame_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Inter-byte timeout in clock cycles for nbytes 10-bit character times.
  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned baud,
                                                 input int unsigned nbytes);
    return (clk_hz / baud) * 10 * nbytes;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: simple dual-port RAM, one write port, one registered read port.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, read-before-write on address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller: SYNC/LEN/payload/CSUM sequencing, inter-byte timeout,
// and a single held payload released by the consumer's acknowledge.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 72_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned MAX_PAYLOAD   = 32,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_BYTES = 4,
  localparam int unsigned LW = $clog2(MAX_PAYLOAD + 1),
  localparam int unsigned AW = $clog2(MAX_PAYLOAD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_error,
  output logic          frame_ready,
  output logic [LW-1:0] frame_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          frame_ack,
  output logic          busy,
  output logic          err_csum,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_rx,
  output logic          drop
);

  localparam int unsigned TMO_LIMIT = timeout_cycles(CLK_FREQ_HZ, BAUD_RATE, TIMEOUT_BYTES);
  localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);

  frame_state_t  state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          frame_ready_d, busy_d, drop_d;
  logic          err_csum_d, err_len_d, err_timeout_d, err_rx_d;
  logic [LW-1:0] frame_len_d;

  logic          in_frame_c, byte_c, len_ok_c, last_c, tmo_exp_c, buf_we_c;

  assign in_frame_c = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  // Within a frame an error on the same cycle as a byte wins over the byte.
  assign byte_c     = rx_valid && !rx_error;
  assign len_ok_c   = (rx_data != 8'd0) && (32'(rx_data) <= MAX_PAYLOAD);
  assign last_c     = (LW'(idx_q) + LW'(1)) == len_q;
  assign tmo_exp_c  = (tmo_q == TW'(TMO_LIMIT - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
    end
  end

  // Registered status outputs and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ready <= 1'b0;
      frame_len   <= '0;
      busy        <= 1'b0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_rx      <= 1'b0;
      drop        <= 1'b0;
    end else begin
      frame_ready <= frame_ready_d;
      frame_len   <= frame_len_d;
      busy        <= busy_d;
      err_csum    <= err_csum_d;
      err_len     <= err_len_d;
      err_timeout <= err_timeout_d;
      err_rx      <= err_rx_d;
      drop        <= drop_d;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    tmo_d         = '0;
    buf_we_c      = 1'b0;
    err_csum_d    = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_rx_d      = 1'b0;
    drop_d        = 1'b0;

    if (in_frame_c) begin
      tmo_d = rx_valid ? '0 : tmo_q + TW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_c) begin
          if (len_ok_c) begin
            len_d   = LW'(rx_data);
            idx_d   = '0;
            csum_d  = rx_data;
            state_d = ST_PAYLOAD;
          end else begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_c) begin
          buf_we_c = 1'b1;
          csum_d   = csum_q ^ rx_data;
          idx_d    = idx_q + AW'(1);
          if (last_c) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (byte_c) begin
          if (rx_data == csum_q) begin
            state_d = ST_HOLD;
          end else begin
            err_csum_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        drop_d = rx_valid;
        if (frame_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame supervision: receiver error first, then timeout if no byte arrived.
    if (in_frame_c && rx_error) begin
      state_d  = ST_IDLE;
      err_rx_d = 1'b1;
    end else if (in_frame_c && !rx_valid && tmo_exp_c) begin
      state_d       = ST_IDLE;
      err_timeout_d = 1'b1;
    end

    if (!((state_d == ST_LEN) || (state_d == ST_PAYLOAD) || (state_d == ST_CSUM))) begin
      tmo_d = '0;
    end

    frame_ready_d = (state_d == ST_HOLD);
    frame_len_d   = (state_d == ST_HOLD) ? len_q : '0;
    busy_d        = (state_d == ST_LEN) || (state_d == ST_PAYLOAD) || (state_d == ST_CSUM);
  end

  uart_frame_buf #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_we_c),
    .wr_addr (idx_q),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames plus randomized
// traffic compared cycle by cycle against a byte-queue frame model.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned MAXP  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned LW    = 6;
  localparam int          LIMIT = 25_000;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_error;
  logic          frame_ready;
  logic [LW-1:0] frame_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_ack;
  logic          busy;
  logic          err_csum, err_len, err_timeout, err_rx, drop;

  uart_rx_frame_ctrl #(
    .CLK_FREQ_HZ   (72_000_000),
    .BAUD_RATE     (115_200),
    .MAX_PAYLOAD   (MAXP),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_BYTES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_error    (rx_error),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ack   (frame_ack),
    .busy        (busy),
    .err_csum    (err_csum),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_rx      (err_rx),
    .drop        (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_act;
  bit         m_hold;
  logic [7:0] fr [$];
  int         m_idle;
  int         m_hlen;
  logic [7:0] mem   [MAXP];
  bit         known [MAXP];

  logic       e_ready, e_busy, e_csum, e_len, e_tmo, e_rx, e_drop;
  int         e_flen;
  logic [7:0] e_rd;
  bit         e_rd_known;

  function automatic void model_reset();
    m_act      = 0;
    m_hold     = 0;
    fr.delete();
    m_idle     = 0;
    m_hlen     = 0;
    e_ready    = 0; e_busy = 0; e_csum = 0; e_len = 0;
    e_tmo      = 0; e_rx = 0;   e_drop = 0;
    e_flen     = 0;
    e_rd       = 8'h00;
    e_rd_known = 1;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d, input logic e,
                                     input logic a, input logic [AW-1:0] ra);
    int n, len;
    logic [7:0] x;
    e_rd_known = known[int'(ra)];
    e_rd       = mem[int'(ra)];
    e_csum = 0; e_len = 0; e_tmo = 0; e_rx = 0; e_drop = 0;
    if (m_hold) begin
      if (v) e_drop = 1;
      if (a) m_hold = 0;
    end else if (m_act) begin
      if (e) begin
        e_rx  = 1;
        m_act = 0;
      end else if (v) begin
        m_idle = 0;
        fr.push_back(d);
        n   = fr.size();
        len = int'(fr[0]);
        if (n == 1) begin
          if (len == 0 || len > MAXP) begin
            e_len = 1;
            m_act = 0;
          end
        end else if (n <= len + 1) begin
          mem[n-2]   = d;
          known[n-2] = 1;
        end else begin
          x = 8'h00;
          for (int i = 0; i <= len; i++) x ^= fr[i];
          if (d == x) begin
            m_hold = 1;
            m_hlen = len;
          end else begin
            e_csum = 1;
          end
          m_act = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == LIMIT) begin
          e_tmo = 1;
          m_act = 0;
        end
      end
    end else if (v && d == SYNC) begin
      m_act  = 1;
      m_idle = 0;
      fr.delete();
    end
    e_ready = m_hold;
    e_busy  = m_act;
    e_flen  = m_hold ? m_hlen : 0;
  endfunction

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("frame_ready", int'(frame_ready), int'(e_ready));
    chk("busy",        int'(busy),        int'(e_busy));
    chk("frame_len",   int'(frame_len),   e_flen);
    chk("err_csum",    int'(err_csum),    int'(e_csum));
    chk("err_len",     int'(err_len),     int'(e_len));
    chk("err_timeout", int'(err_timeout), int'(e_tmo));
    chk("err_rx",      int'(err_rx),      int'(e_rx));
    chk("drop",        int'(drop),        int'(e_drop));
    if (e_rd_known) chk("rd_data", int'(rd_data), int'(e_rd));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic v, input logic [7:0] d, input logic e, input logic a);
    rx_valid  = v;
    rx_data   = d;
    rx_error  = e;
    frame_ack = a;
    @(posedge clk);
    model_step(v, d, e, a, rd_addr);
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_error  = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rtick(input logic v, input logic [7:0] d, input logic e, input logic a);
    rd_addr = AW'($urandom_range(0, MAXP - 1));
    tick(v, d, e, a);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3))
      rtick(1'b0, 8'h00, 1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) == 0));
  endtask

  task automatic rand_frame();
    int kind, len;
    logic [7:0] x, b;
    kind = $urandom_range(0, 9);
    if (kind == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXP + 1, 255);
    else           len = $urandom_range(1, MAXP);
    gap(); rtick(1'b1, SYNC, 1'b0, 1'b0);
    gap(); rtick(1'b1, 8'(len), 1'b0, 1'b0);
    if (kind == 0) return;
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      x ^= b;
      gap();
      if (kind == 1 && i == len / 2) begin
        rtick(1'b1, b, 1'b1, 1'b0);
        return;
      end
      rtick(1'b1, b, 1'b0, 1'b0);
    end
    gap();
    if (kind == 2) x ^= 8'($urandom_range(1, 255));
    rtick(1'b1, x, 1'b0, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] pay [MAXP];
    logic [7:0] x;

    for (int i = 0; i < int'(MAXP); i++) begin
      known[i] = 0;
      mem[i]   = 8'h00;
    end
    rst_n     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    rx_error  = 1'b0;
    frame_ack = 1'b0;
    rd_addr   = '0;
    model_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("reset frame_ready", int'(frame_ready), 0);
    chk("reset busy",        int'(busy),        0);
    chk("reset frame_len",   int'(frame_len),   0);
    chk("reset rd_data",     int'(rd_data),     0);
    chk("reset drop",        int'(drop),        0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Valid frame A5 03 11 22 33 03.
    send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("valid busy before csum", int'(busy), 1);
    send(8'h03);
    chk("valid frame_ready", int'(frame_ready), 1);
    chk("valid frame_len",   int'(frame_len),   3);
    chk("valid busy",        int'(busy),        0);
    rd_addr = 5'd0; idle(1); chk("read addr0", int'(rd_data), 8'h11);
    rd_addr = 5'd1; idle(1); chk("read addr1", int'(rd_data), 8'h22);
    rd_addr = 5'd2; idle(1); chk("read addr2", int'(rd_data), 8'h33);

    // Hold: five bytes dropped, buffer unchanged.
    for (int i = 0; i < 5; i++) begin
      rd_addr = AW'(i % 3);
      send(SYNC ^ 8'(i));
      chk("hold drop", int'(drop), 1);
      chk("hold frame_ready", int'(frame_ready), 1);
    end
    rd_addr = 5'd1; idle(1); chk("hold buffer addr1", int'(rd_data), 8'h22);
    chk("hold frame_len", int'(frame_len), 3);
    // Ack with a SYNC byte in the same cycle: dropped, not taken as SYNC.
    tick(1'b1, SYNC, 1'b0, 1'b1);
    chk("ack drop",        int'(drop),        1);
    chk("ack frame_ready", int'(frame_ready), 0);
    chk("ack frame_len",   int'(frame_len),   0);
    idle(1);
    chk("ack byte not sync", int'(busy), 0);

    // Bad checksum A5 02 10 20 FF (expected 0x32).
    send(SYNC); send(8'h02); send(8'h10); send(8'h20); send(8'hFF);
    chk("bad csum pulse",       int'(err_csum),    1);
    chk("bad csum frame_ready", int'(frame_ready), 0);
    chk("bad csum busy",        int'(busy),        0);
    idle(1);
    chk("bad csum single pulse", int'(err_csum), 0);

    // Length bounds.
    send(SYNC); send(8'h00);
    chk("len zero", int'(err_len), 1);
    send(SYNC); send(8'h21);
    chk("len 33", int'(err_len), 1);
    chk("len 33 busy", int'(busy), 0);
    send(SYNC); send(8'h20);
    x = 8'h20;
    for (int i = 0; i < int'(MAXP); i++) begin
      pay[i] = 8'(i * 7 + 1);
      x ^= pay[i];
      send(pay[i]);
    end
    send(x);
    chk("len 32 accepted", int'(frame_ready), 1);
    chk("len 32 frame_len", int'(frame_len), 32);
    rd_addr = 5'd31; idle(1); chk("len 32 last byte", int'(rd_data), int'(pay[31]));

    // Back-to-back SYNC right after leaving HOLD, then rx_error mid-PAYLOAD.
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("release frame_ready", int'(frame_ready), 0);
    send(SYNC);
    chk("back-to-back sync", int'(busy), 1);
    send(8'h02); send(8'h10);
    tick(1'b1, 8'h20, 1'b1, 1'b0);
    chk("rx error pulse", int'(err_rx), 1);
    chk("rx error busy",  int'(busy),   0);

    // Timeout after 25000 silent cycles.
    send(SYNC); send(8'h02); send(8'h10);
    idle(LIMIT - 1);
    chk("timeout not yet", int'(err_timeout), 0);
    chk("timeout busy",    int'(busy),        1);
    idle(1);
    chk("timeout pulse", int'(err_timeout), 1);
    chk("timeout busy cleared", int'(busy), 0);

    // Byte on the expiry cycle is processed instead.
    send(SYNC); send(8'h02); send(8'h10);
    idle(LIMIT - 1);
    send(8'h20);
    chk("expiry byte no timeout", int'(err_timeout), 0);
    chk("expiry byte busy",       int'(busy),        1);
    send(8'h32);
    chk("expiry frame_ready", int'(frame_ready), 1);
    chk("expiry frame_len",   int'(frame_len),   2);
    tick(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-PAYLOAD, then a clean frame.
    send(SYNC); send(8'h04); send(8'h01); send(8'h02);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset busy",        int'(busy),        0);
    chk("midreset frame_ready", int'(frame_ready), 0);
    chk("midreset rd_data",     int'(rd_data),     0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(SYNC); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
    chk("post reset frame_ready", int'(frame_ready), 1);
    chk("post reset frame_len",   int'(frame_len),   2);
    rd_addr = 5'd1; idle(1); chk("post reset read", int'(rd_data), 8'hBB);
    tick(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 3) == 0) rtick(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      rand_frame();
      if (m_hold) begin
        repeat ($urandom_range(0, 4))
          rtick(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        rtick(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
